load_store_unit: RTL and testbench

//  CPU-side initiator for the data-memory bus (ReadEnable/WriteEnable/ByteEnable/Address/WriteData/ReadData).

---
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: MIPS data-memory bus initiator for lb/lh/lw/lbu/lhu/sb/sh/sw
// with byte-lane steering, load extension and AdEL/AdES detection before any bus activity.
module load_store_unit #(
  parameter logic [31:0] DATA_BASE    = 32'h1001_0000,
  parameter logic [31:0] DATA_END     = 32'h1001_1FFF,
  parameter logic [31:0] KDATA_BASE   = 32'h9000_0000,
  parameter logic [31:0] KDATA_END    = 32'h9000_07FF,
  parameter int          READ_LATENCY = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iStart,
  input  logic        iIsStore,
  input  logic [1:0]  iSize,
  input  logic        iUnsigned,
  input  logic        iKernelMode,
  input  logic [31:0] iAddress,
  input  logic [31:0] iStoreData,
  output logic        oBusy,
  output logic        oDone,
  output logic [31:0] oLoadData,
  output logic        oException,
  output logic [4:0]  oExcCode,
  output logic [31:0] oBadVAddr,
  output logic        oReadEnable,
  output logic        oWriteEnable,
  output logic [3:0]  oByteEnable,
  output logic [31:0] oAddress,
  output logic [31:0] oWriteData,
  input  logic [31:0] iReadData
);
  localparam logic [2:0] S_IDLE = 3'd0, S_ACCESS = 3'd1, S_WAIT = 3'd2, S_DONE = 3'd3, S_FAULT = 3'd4;
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  logic [2:0]    r_state;
  logic          r_busy, r_done, r_exc, r_re, r_we, r_st, r_uns;
  logic [4:0]    r_code;
  logic [3:0]    r_be;
  logic [1:0]    r_size;
  logic [31:0]   r_ld, r_bad, r_addr, r_wd, r_cap_addr, r_cap_data;
  logic [CW-1:0] r_cnt;
  logic          w_accept, w_mis, w_unmapped, w_byte, w_half;
  logic [3:0]    w_be;
  logic [7:0]    w_rd_byte;
  logic [15:0]   w_rd_half;
  logic [31:0]   w_wd, w_ext;
  always_comb begin
    w_accept   = iStart && !r_busy && r_state == S_IDLE;
    w_mis      = (iSize == 2'b01 && iAddress[0]) || (iSize[1] && iAddress[1:0] != 2'b00);
    w_unmapped = !(iAddress >= DATA_BASE && iAddress <= DATA_END) &&
                 !(iKernelMode && iAddress >= KDATA_BASE && iAddress <= KDATA_END);
    w_byte     = r_size == 2'b00;
    w_half     = r_size == 2'b01;
    w_be       = w_byte ? 4'b0001 << r_cap_addr[1:0] : w_half ? (r_cap_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_wd       = w_byte ? {4{r_cap_data[7:0]}} : w_half ? {2{r_cap_data[15:0]}} : r_cap_data;
    w_rd_byte  = iReadData[{r_cap_addr[1:0], 3'b000} +: 8];
    w_rd_half  = r_cap_addr[1] ? iReadData[31:16] : iReadData[15:0];
    w_ext      = w_byte ? {{24{!r_uns && w_rd_byte[7]}}, w_rd_byte} :
                 w_half ? {{16{!r_uns && w_rd_half[15]}}, w_rd_half} : iReadData;
  end
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_exc      <= 1'b0;
      r_code     <= 5'd0;
      r_re       <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= 4'd0;
      r_ld       <= 32'd0;
      r_bad      <= 32'd0;
      r_addr     <= 32'd0;
      r_wd       <= 32'd0;
      r_st       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= 2'd0;
      r_cap_addr <= 32'd0;
      r_cap_data <= 32'd0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // busy stays high through the oDone cycle, so a start there is ignored
          r_busy <= w_accept;
          r_done <= 1'b0;
          r_exc  <= 1'b0;
          r_code <= 5'd0;
          if (w_accept) begin
            r_st       <= iIsStore;
            r_size     <= iSize;
            r_uns      <= iUnsigned;
            r_cap_addr <= iAddress;
            r_cap_data <= iStoreData;
            r_state    <= (w_mis || w_unmapped) ? S_FAULT : S_ACCESS;
          end
        end
        S_FAULT: begin
          r_done  <= 1'b1;
          r_exc   <= 1'b1;
          r_code  <= r_st ? 5'd5 : 5'd4;
          r_bad   <= r_cap_addr;
          r_state <= S_IDLE;
        end
        S_ACCESS: begin
          r_addr <= r_cap_addr;
          r_be   <= w_be;
          r_cnt  <= '0;
          if (r_st) begin
            r_we    <= 1'b1;
            r_wd    <= w_wd;
            r_state <= S_DONE;
          end else begin
            r_re    <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == CW'(READ_LATENCY - 1)) begin
            r_ld    <= w_ext;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_re    <= 1'b0;
          r_we    <= 1'b0;
          r_be    <= 4'd0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign oBusy        = r_busy;
  assign oDone        = r_done;
  assign oLoadData    = r_ld;
  assign oException   = r_exc;
  assign oExcCode     = r_code;
  assign oBadVAddr    = r_bad;
  assign oReadEnable  = r_re;
  assign oWriteEnable = r_we;
  assign oByteEnable  = r_be;
  assign oAddress     = r_addr;
  assign oWriteData   = r_wd;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors; expected responses are queued at issue
// and a negedge monitor checks bus activity and completions against the queue head.
module tb_load_store_unit;
  logic        iCLK = 1'b0, iRST = 1'b1, iStart = 1'b0, iIsStore = 1'b0, iUnsigned = 1'b0, iKernelMode = 1'b0;
  logic [1:0]  iSize = 2'd0;
  logic [31:0] iAddress = 32'd0, iStoreData = 32'd0, iReadData;
  logic        oBusy, oDone, oException, oReadEnable, oWriteEnable;
  logic [4:0]  oExcCode;
  logic [3:0]  oByteEnable;
  logic [31:0] oLoadData, oBadVAddr, oAddress, oWriteData;
  logic [31:0] mem_word = 32'd0, last_ld = 32'd0, last_bad = 32'd0;
  int checks = 0, failures = 0, cyc = 0, re_n = 0, we_n = 0;
  typedef struct {
    logic [4:0]  code;
    logic [31:0] ld, bad, addr, wd;
    logic [3:0]  be;
    int          lat, k, re_n, we_n;
  } txn_t;
  txn_t sq[$];

  always #5 iCLK = ~iCLK;
  always @(posedge iCLK) cyc <= cyc + 1;
  assign iReadData = oReadEnable ? mem_word : 32'h0;

  load_store_unit dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iIsStore(iIsStore), .iSize(iSize),
    .iUnsigned(iUnsigned), .iKernelMode(iKernelMode), .iAddress(iAddress), .iStoreData(iStoreData),
    .oBusy(oBusy), .oDone(oDone), .oLoadData(oLoadData), .oException(oException), .oExcCode(oExcCode),
    .oBadVAddr(oBadVAddr), .oReadEnable(oReadEnable), .oWriteEnable(oWriteEnable),
    .oByteEnable(oByteEnable), .oAddress(oAddress), .oWriteData(oWriteData), .iReadData(iReadData)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge iCLK) begin
    txn_t t;
    if (!iRST) begin
      if (oReadEnable || oWriteEnable) begin
        if (sq.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
        else begin
          chk("bus_addr", oAddress, sq[0].addr);
          chk("bus_be", {28'd0, oByteEnable}, {28'd0, sq[0].be});
          if (oWriteEnable) chk("bus_wdata", oWriteData, sq[0].wd);
        end
        if (oReadEnable) re_n++;
        if (oWriteEnable) we_n++;
      end
      if (oDone) begin
        if (sq.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
        else begin
          t = sq.pop_front();
          chk("exception", {31'd0, oException}, {31'd0, t.code != 5'd0});
          chk("exccode", {27'd0, oExcCode}, {27'd0, t.code});
          chk("loaddata", oLoadData, t.ld);
          chk("badvaddr", oBadVAddr, t.bad);
          chk("latency", 32'(cyc - t.k - 1), 32'(t.lat));
          chk("re_cycles", 32'(re_n), 32'(t.re_n));
          chk("we_cycles", 32'(we_n), 32'(t.we_n));
        end
        re_n = 0;
        we_n = 0;
      end
    end
  end

  task automatic run(input string nm, input logic st, input logic [1:0] sz, input logic un, input logic kern,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] w, input logic fault,
                     input logic [31:0] eld, input logic [3:0] ebe, input logic [31:0] ewd, input logic poke);
    txn_t t;
    iIsStore = st; iSize = sz; iUnsigned = un; iKernelMode = kern; iAddress = a; iStoreData = d;
    mem_word = w; iStart = 1'b1;
    if (!fault && !st) last_ld = eld;
    if (fault) last_bad = a;
    t.code = fault ? (st ? 5'd5 : 5'd4) : 5'd0;
    t.ld = last_ld; t.bad = last_bad; t.addr = a; t.be = ebe; t.wd = ewd;
    t.lat = fault ? 1 : st ? 2 : 3;
    t.re_n = (fault || st) ? 0 : 2;
    t.we_n = (!fault && st) ? 1 : 0;
    t.k = cyc;
    sq.push_back(t);
    @(negedge iCLK);
    iStart = 1'b0;
    chk({nm, " busy"}, {31'd0, oBusy}, 32'd1);
    if (poke) begin
      iIsStore = 1'b1; iSize = 2'b10; iAddress = 32'h1001_0010; iStoreData = 32'h5555_AAAA; iStart = 1'b1;
      @(negedge iCLK);
      iStart = 1'b0;
    end
    for (int i = 0; i < 20 && !oDone; i++) @(negedge iCLK);
    if (!oDone) chk({nm, " done_timeout"}, 32'd0, 32'd1);
    @(negedge iCLK);
    chk({nm, " idle_busy"}, {31'd0, oBusy}, 32'd0);
    chk({nm, " idle_be"}, {28'd0, oByteEnable}, 32'd0);
  endtask

  initial begin
    txn_t t;
    repeat (3) @(negedge iCLK);
    chk("rst_busy", {31'd0, oBusy}, 32'd0);
    chk("rst_done", {31'd0, oDone}, 32'd0);
    chk("rst_en", {26'd0, oReadEnable, oWriteEnable, oByteEnable}, 32'd0);
    chk("rst_ld", oLoadData, 32'd0);
    chk("rst_addr", oAddress, 32'd0);
    iRST = 1'b0;
    @(negedge iCLK);
    //   name        st  sz   un kern addr            store data      mem word        flt eld             be       wd
    run("sw",        1, 2'd2, 0, 0, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0,         0, 32'h0,         4'b1111, 32'hDEAD_BEEF, 0);
    run("sb",        1, 2'd0, 0, 0, 32'h1001_0003, 32'h1234_56AB, 32'h0,         0, 32'h0,         4'b1000, 32'hABAB_ABAB, 0);
    run("sh",        1, 2'd1, 0, 0, 32'h1001_0002, 32'h1234_BEEF, 32'h0,         0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 0);
    run("s_size3",   1, 2'd3, 0, 0, 32'h1001_0008, 32'h0102_0304, 32'h0,         0, 32'h0,         4'b1111, 32'h0102_0304, 0);
    run("lb1",       0, 2'd0, 0, 0, 32'h1001_0001, 32'h0,         32'h80FF_7F01, 0, 32'h0000_007F, 4'b0010, 32'h0, 0);
    run("lb3",       0, 2'd0, 0, 0, 32'h1001_0003, 32'h0,         32'h80FF_7F01, 0, 32'hFFFF_FF80, 4'b1000, 32'h0, 0);
    run("lbu2",      0, 2'd0, 1, 0, 32'h1001_0002, 32'h0,         32'h80FF_7F01, 0, 32'h0000_00FF, 4'b0100, 32'h0, 0);
    run("lh2",       0, 2'd1, 0, 0, 32'h1001_0002, 32'h0,         32'h80FF_7F01, 0, 32'hFFFF_80FF, 4'b1100, 32'h0, 0);
    run("lhu2",      0, 2'd1, 1, 0, 32'h1001_0002, 32'h0,         32'h80FF_7F01, 0, 32'h0000_80FF, 4'b1100, 32'h0, 0);
    run("lw0",       0, 2'd2, 0, 0, 32'h1001_0000, 32'h0,         32'h80FF_7F01, 0, 32'h80FF_7F01, 4'b1111, 32'h0, 0);
    run("lw_mis",    0, 2'd2, 0, 0, 32'h1001_0002, 32'h0,         32'h0,         1, 32'h0,         4'b0000, 32'h0, 0);
    run("sh_unmap",  1, 2'd1, 0, 0, 32'h0000_0000, 32'h1111_2222, 32'h0,         1, 32'h0,         4'b0000, 32'h0, 0);
    run("sh_mis",    1, 2'd1, 0, 0, 32'h1001_0001, 32'h1111_2222, 32'h0,         1, 32'h0,         4'b0000, 32'h0, 0);
    run("lw_kuser",  0, 2'd2, 0, 0, 32'h9000_0010, 32'h0,         32'h0,         1, 32'h0,         4'b0000, 32'h0, 0);
    run("lw_kern",   0, 2'd2, 0, 1, 32'h9000_0010, 32'h0,         32'hCAFE_F00D, 0, 32'hCAFE_F00D, 4'b1111, 32'h0, 0);
    run("lh_end",    0, 2'd1, 0, 0, 32'h1001_1FFE, 32'h0,         32'h7FFF_1234, 0, 32'h0000_7FFF, 4'b1100, 32'h0, 0);
    run("lb_past",   0, 2'd0, 0, 0, 32'h1001_2000, 32'h0,         32'h0,         1, 32'h0,         4'b0000, 32'h0, 0);
    run("sb_below",  1, 2'd0, 0, 0, 32'h1000_FFFF, 32'h0000_0077, 32'h0,         1, 32'h0,         4'b0000, 32'h0, 0);
    run("lhu_kpast", 0, 2'd1, 1, 1, 32'h9000_0800, 32'h0,         32'h0,         1, 32'h0,         4'b0000, 32'h0, 0);
    // reset while a load sits in WAIT: the pending completion must never appear
    mem_word = 32'h80FF_7F01; iIsStore = 1'b0; iSize = 2'd2; iUnsigned = 1'b0; iAddress = 32'h1001_0000; iStart = 1'b1;
    t.code = 5'd0; t.ld = 32'h0; t.bad = 32'h0; t.addr = 32'h1001_0000; t.be = 4'b1111; t.wd = 32'h0;
    t.lat = 3; t.re_n = 2; t.we_n = 0; t.k = cyc;
    sq.push_back(t);
    @(negedge iCLK);
    iStart = 1'b0;
    @(negedge iCLK);
    chk("rstmid_pre_re", {31'd0, oReadEnable}, 32'd1);
    iRST = 1'b1;
    @(negedge iCLK);
    chk("rstmid_re", {31'd0, oReadEnable}, 32'd0);
    chk("rstmid_busy", {31'd0, oBusy}, 32'd0);
    chk("rstmid_done", {31'd0, oDone}, 32'd0);
    chk("rstmid_ld", oLoadData, 32'd0);
    sq.delete();
    re_n = 0; we_n = 0; last_ld = 32'd0; last_bad = 32'd0;
    iRST = 1'b0;
    repeat (2) @(negedge iCLK);
    chk("rstmid_no_done", {31'd0, oDone}, 32'd0);
    run("lw_after_rst", 0, 2'd2, 0, 0, 32'h1001_0000, 32'h0,      32'h80FF_7F01, 0, 32'h80FF_7F01, 4'b1111, 32'h0, 1);
    run("sb_after_rst", 1, 2'd0, 0, 0, 32'h1001_0001, 32'h0000_00C3, 32'h0,      0, 32'h0,         4'b0010, 32'hC3C3_C3C3, 1);
    repeat (4) @(negedge iCLK);
    chk("queue_empty", 32'(sq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
